// File: rtl/chime_alarm_scheduler.sv
// Arbitrates the shared tone path and alarm LED between the alarm match
// and the hourly chime; the alarm always preempts the chime.
module chime_alarm_scheduler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 300,
  parameter int ALARM_SECS = 30
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       sec_tick,
  input  logic [5:0] clock_hour,
  input  logic [5:0] clock_minute,
  input  logic [5:0] clock_second,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_minute,
  input  logic [5:0] alarm_second,
  input  logic       alarm_armed,
  input  logic       chime_en,
  input  logic       alarm_stop,
  output logic       tone_req,
  output logic [1:0] tone_sel,
  output logic       alarm_led,
  output logic       busy
);

  localparam int BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  localparam int MAX_CYC  = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int CW       = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [5:0]    SECS_LAST = 6'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHIME_ON,
    S_CHIME_GAP,
    S_ALARM
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [3:0]    r_beeps;
  logic [5:0]    r_secs;

  logic       w_time_match;
  logic       w_alarm_hit;
  logic       w_chime_hit;
  logic [5:0] w_h12;
  logic [3:0] w_hour_beeps;

  assign w_time_match = (clock_hour   == alarm_hour)
                      & (clock_minute == alarm_minute)
                      & (clock_second == alarm_second);
  assign w_alarm_hit  = sec_tick & alarm_armed & w_time_match;
  assign w_chime_hit  = sec_tick & chime_en
                      & (clock_minute == 6'd0)
                      & (clock_second == 6'd0);

  // Hour 0 and 12 both strike twelve.
  assign w_h12 = (clock_hour >= 6'd12) ? clock_hour - 6'd12 : clock_hour;
  assign w_hour_beeps = (w_h12 == 6'd0) ? 4'd12 : 4'(w_h12);

  always_ff @(posedge CLK_50) begin
    if (reset_en) begin
      r_state   <= S_IDLE;
      r_cyc     <= '0;
      r_beeps   <= '0;
      r_secs    <= '0;
      tone_req  <= 1'b0;
      tone_sel  <= 2'd0;
      alarm_led <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_alarm_hit && !alarm_stop) begin
            r_state   <= S_ALARM;
            r_secs    <= '0;
            tone_req  <= 1'b1;
            tone_sel  <= 2'd2;
            alarm_led <= 1'b1;
            busy      <= 1'b1;
          end else if (w_chime_hit) begin
            r_state  <= S_CHIME_ON;
            r_beeps  <= w_hour_beeps;
            r_cyc    <= '0;
            tone_req <= 1'b1;
            tone_sel <= 2'd1;
            busy     <= 1'b1;
          end
        end
        S_CHIME_ON, S_CHIME_GAP: begin
          if (w_alarm_hit) begin
            r_state   <= S_ALARM;
            r_secs    <= '0;
            r_beeps   <= '0;
            r_cyc     <= '0;
            tone_req  <= 1'b1;
            tone_sel  <= 2'd2;
            alarm_led <= 1'b1;
          end else if (r_state == S_CHIME_ON) begin
            if (r_cyc == BEEP_LAST) begin
              r_cyc    <= '0;
              r_beeps  <= r_beeps - 4'd1;
              tone_req <= 1'b0;
              tone_sel <= 2'd0;
              if (r_beeps == 4'd1) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_CHIME_GAP;
              end
            end else begin
              r_cyc <= r_cyc + 1'b1;
            end
          end else if (r_cyc == GAP_LAST) begin
            r_cyc    <= '0;
            r_state  <= S_CHIME_ON;
            tone_req <= 1'b1;
            tone_sel <= 2'd1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_ALARM: begin
          // Cancel and disarm take effect on any cycle, not just on ticks.
          if (alarm_stop || !alarm_armed ||
              (sec_tick && r_secs == SECS_LAST)) begin
            r_state   <= S_IDLE;
            r_secs    <= '0;
            tone_req  <= 1'b0;
            tone_sel  <= 2'd0;
            alarm_led <= 1'b0;
            busy      <= 1'b0;
          end else if (sec_tick) begin
            r_secs    <= r_secs + 6'd1;
            alarm_led <= ~alarm_led;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chime_alarm_scheduler.sv
// Bench for chime_alarm_scheduler: vector table, corner sequences and
// randomized traffic against a timeline-based reference model.
module tb_chime_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst, tick, armed, cen, stop;
  logic [5:0] ch, cm, cs, ah, am, as;
  logic       tone_req, alarm_led, busy;
  logic [1:0] tone_sel;

  int n_vec = 0;
  int n_bad = 0;
  bit rand_on = 1'b0;

  always #5 clk = ~clk;

  chime_alarm_scheduler #(
    .CLK_HZ(1000), .BEEP_MS(5), .GAP_MS(3), .ALARM_SECS(30)
  ) dut (
    .CLK_50(clk), .reset_en(rst), .sec_tick(tick),
    .clock_hour(ch), .clock_minute(cm), .clock_second(cs),
    .alarm_hour(ah), .alarm_minute(am), .alarm_second(as),
    .alarm_armed(armed), .chime_en(cen), .alarm_stop(stop),
    .tone_req(tone_req), .tone_sel(tone_sel),
    .alarm_led(alarm_led), .busy(busy)
  );

  // Model: a chime is a timeline of N beeps (5 on, 3 off); an alarm is
  // a count of elapsed seconds with the LED lit on even counts.
  int m_beeps = 0;
  int m_t     = 0;
  int m_ticks = 0;
  bit m_alarm = 1'b0;

  task automatic model_step();
    bit ha, hc;
    ha = tick && armed && ch == ah && cm == am && cs == as;
    hc = tick && cen && cm == 0 && cs == 0;
    if (rst) begin
      m_alarm = 1'b0;
      m_beeps = 0;
    end else if (m_alarm) begin
      if (stop || !armed) m_alarm = 1'b0;
      else if (tick) begin
        m_ticks++;
        if (m_ticks == 30) m_alarm = 1'b0;
      end
    end else if (ha && (m_beeps > 0 || !stop)) begin
      m_alarm = 1'b1;
      m_ticks = 0;
      m_beeps = 0;
    end else if (m_beeps > 0) begin
      m_t++;
      if (m_t == 8 * m_beeps - 3) m_beeps = 0;
    end else if (hc) begin
      m_beeps = (ch % 12 == 0) ? 12 : int'(ch % 12);
      m_t = 0;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_cmp();
    bit on;
    on = m_alarm || (m_beeps > 0 && (m_t % 8) < 5);
    chk("rnd_req", 8'(tone_req), 8'(on));
    chk("rnd_sel", 8'(tone_sel), m_alarm ? 8'd2 : (on ? 8'd1 : 8'd0));
    chk("rnd_led", 8'(alarm_led), 8'(m_alarm && (m_ticks % 2 == 0)));
    chk("rnd_busy", 8'(busy), 8'(m_alarm || m_beeps > 0));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (rand_on) model_cmp();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; stop = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    ch = 6'(h); cm = 6'(m); cs = 6'(s);
  endtask

  task automatic set_alarm(input int h, input int m, input int s);
    ah = 6'(h); am = 6'(m); as = 6'(s);
  endtask

  typedef struct {
    int   h, m, s, a_h, a_m, a_s;
    logic arm, ce, stp, tk;
    logic req;
    logic [1:0] sel;
    logic led, bsy;
    int   beeps;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int pulses, hi, len, cnt;
    logic prev;

    tbl[0]  = '{15,0,0,  7,30,0, 1,1,0,1, 1,2'd1,0,1, 3};
    tbl[1]  = '{0,0,0,   7,30,0, 1,1,0,1, 1,2'd1,0,1, 12};
    tbl[2]  = '{12,0,0,  7,30,0, 1,1,0,1, 1,2'd1,0,1, 12};
    tbl[3]  = '{13,0,0,  7,30,0, 1,1,0,1, 1,2'd1,0,1, 1};
    tbl[4]  = '{13,0,1,  7,30,0, 1,1,0,1, 0,2'd0,0,0, 0};
    tbl[5]  = '{15,0,0,  7,30,0, 1,0,0,1, 0,2'd0,0,0, 0};
    tbl[6]  = '{15,0,0,  7,30,0, 1,1,0,0, 0,2'd0,0,0, 0};
    tbl[7]  = '{7,30,0,  7,30,0, 1,1,0,1, 1,2'd2,1,1, -1};
    tbl[8]  = '{7,30,0,  7,30,0, 0,1,0,1, 0,2'd0,0,0, 0};
    tbl[9]  = '{7,30,0,  7,30,0, 1,1,1,1, 0,2'd0,0,0, 0};
    tbl[10] = '{8,0,0,   8,0,0,  1,1,0,1, 1,2'd2,1,1, -1};
    tbl[11] = '{23,0,0,  7,30,0, 1,1,0,1, 1,2'd1,0,1, 11};

    rst = 1'b1; tick = 1'b0; stop = 1'b0; armed = 1'b0; cen = 1'b0;
    set_time(0, 0, 1);
    set_alarm(7, 30, 0);
    step();
    chk("reset_req", 8'(tone_req), 8'd0);
    chk("reset_sel", 8'(tone_sel), 8'd0);
    chk("reset_led", 8'(alarm_led), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      set_time(tbl[i].h, tbl[i].m, tbl[i].s);
      set_alarm(tbl[i].a_h, tbl[i].a_m, tbl[i].a_s);
      armed = tbl[i].arm; cen = tbl[i].ce;
      stop = tbl[i].stp; tick = tbl[i].tk;
      step();
      tick = 1'b0; stop = 1'b0;
      chk($sformatf("v%0d_req", i), 8'(tone_req), 8'(tbl[i].req));
      chk($sformatf("v%0d_sel", i), 8'(tone_sel), 8'(tbl[i].sel));
      chk($sformatf("v%0d_led", i), 8'(alarm_led), 8'(tbl[i].led));
      chk($sformatf("v%0d_busy", i), 8'(busy), 8'(tbl[i].bsy));
      if (tbl[i].beeps >= 0) begin
        pulses = tone_req ? 1 : 0;
        hi = pulses;
        len = busy ? 1 : 0;
        prev = tone_req;
        for (int k = 0; k < 200 && busy; k++) begin
          step();
          if (tone_req && !prev) pulses++;
          if (tone_req) hi++;
          if (busy) len++;
          prev = tone_req;
        end
        chk($sformatf("v%0d_idle_timeout", i), 8'(busy), 8'd0);
        chk($sformatf("v%0d_beeps", i), 8'(pulses), 8'(tbl[i].beeps));
        chk($sformatf("v%0d_on_cycles", i), 8'(hi), 8'(5 * tbl[i].beeps));
        chk($sformatf("v%0d_length", i), 8'(len),
            (tbl[i].beeps > 0) ? 8'(8 * tbl[i].beeps - 3) : 8'd0);
      end
    end

    // Reset held mid-beep
    do_reset();
    armed = 1'b0; cen = 1'b1;
    set_time(15, 0, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step();
    chk("s1_pre_req", 8'(tone_req), 8'd1);
    rst = 1'b1;
    step();
    chk("s1_rst_req", 8'(tone_req), 8'd0);
    chk("s1_rst_sel", 8'(tone_sel), 8'd0);
    chk("s1_rst_busy", 8'(busy), 8'd0);
    step(); step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tone_req || busy) cnt++;
    end
    chk("s1_no_beeps", 8'(cnt), 8'd0);

    // Full alarm run to timeout
    do_reset();
    armed = 1'b1; cen = 1'b1;
    set_alarm(7, 30, 0);
    set_time(7, 30, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("s4_sel", 8'(tone_sel), 8'd2);
    chk("s4_led0", 8'(alarm_led), 8'd1);
    for (int i = 1; i <= 30; i++) begin
      step();
      set_time(7, 30, i);
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i < 30) begin
        chk($sformatf("s4_led%0d", i), 8'(alarm_led), 8'(i % 2 == 0));
        chk($sformatf("s4_busy%0d", i), 8'(busy), 8'd1);
      end else begin
        chk("s4_end_busy", 8'(busy), 8'd0);
        chk("s4_end_req", 8'(tone_req), 8'd0);
        chk("s4_end_led", 8'(alarm_led), 8'd0);
      end
    end

    // Alarm preempts beep 2 of a 9-beep chime, then stop
    do_reset();
    armed = 1'b1; cen = 1'b1;
    set_alarm(9, 0, 10);
    set_time(9, 0, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("s5_in_beep2", 8'(tone_sel), 8'd1);
    set_time(9, 0, 10);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("s5_alarm_sel", 8'(tone_sel), 8'd2);
    chk("s5_alarm_led", 8'(alarm_led), 8'd1);
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("s5_stop_req", 8'(tone_req), 8'd0);
    chk("s5_stop_busy", 8'(busy), 8'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tone_req) cnt++;
    end
    chk("s5_no_chime", 8'(cnt), 8'd0);

    // Disarm mid-alarm
    do_reset();
    armed = 1'b1; cen = 1'b0;
    set_alarm(6, 15, 0);
    set_time(6, 15, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step();
    chk("s6_active", 8'(tone_sel), 8'd2);
    armed = 1'b0;
    step();
    chk("s6_req", 8'(tone_req), 8'd0);
    chk("s6_busy", 8'(busy), 8'd0);

    // Randomized traffic against the model
    do_reset();
    rand_on = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick = ($urandom_range(0, 3) == 0);
      ch = 6'($urandom_range(0, 23));
      cm = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      cs = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
      if ($urandom_range(0, 15) == 0) begin
        ah = ch; am = cm; as = cs;
      end else begin
        ah = 6'($urandom_range(0, 23));
        am = 6'($urandom_range(0, 59));
        as = 6'($urandom_range(0, 59));
      end
      armed = ($urandom_range(0, 199) != 0);
      cen = ($urandom_range(0, 7) != 0);
      stop = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rand_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
